// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the 160x120 framebuffer scan-out.
//   - colour type and named colours
//   - framebuffer geometry and 640x480@60 timing constants
//   - fb_addr(): framebuffer cell address y*160+x built from shifts
package vga_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int FB_WIDTH      = 160;
    localparam int SCALE_SHIFT   = 2;
    localparam int ADDR_W        = 15;
    localparam int CNT_W         = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [2:0] colour_t;

    localparam colour_t BLACK  = 3'b000;
    localparam colour_t BLUE   = 3'b001;
    localparam colour_t GREEN  = 3'b010;
    localparam colour_t YELLOW = 3'b110;
    localparam colour_t RED    = 3'b100;
    localparam colour_t WHITE  = 3'b111;

    // y*160 + x as (y<<7)+(y<<5)+x; 119*160+159 = 19199 fits in 15 bits.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] xx, input logic [6:0] yy);
        logic [ADDR_W-1:0] y_w;
        y_w = {8'd0, yy};
        return (y_w << 7) + (y_w << 5) + {7'd0, xx};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-phase toggle, horizontal/vertical counters and decode.
//   clk, resetn    : system clock, synchronous active-low reset
//   o_phase        : pixel phase bit (VGA_CLK is its inverse)
//   o_pix_tick     : high on the clk edge where the counters advance
//   o_h_cnt/v_cnt  : current scan position
//   o_visible      : position lies in the active area
//   o_hsync_n/vsync_n : sync levels for the current position (active low)
//   o_vblank       : v_cnt in vertical blanking
//   o_frame_wrap   : this tick moves the scan from the last visible line into vblank
module vga_timing #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      o_phase,
    output logic                      o_pix_tick,
    output logic [vga_pkg::CNT_W-1:0] o_h_cnt,
    output logic [vga_pkg::CNT_W-1:0] o_v_cnt,
    output logic                      o_visible,
    output logic                      o_hsync_n,
    output logic                      o_vsync_n,
    output logic                      o_vblank,
    output logic                      o_frame_wrap
);
    import vga_pkg::*;

    localparam int HT       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 1;

    logic             r_phase;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_pix_tick;
    logic             w_h_last;

    // Tick while phase is 0, so the very first edge out of reset already
    // advances the scan and the pipeline updates on VGA_CLK falling edges.
    assign w_pix_tick = ~r_phase;
    assign w_h_last   = (r_h_cnt == CNT_W'(HT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_phase <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (w_pix_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == CNT_W'(VT - 1)) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign o_phase      = r_phase;
    assign o_pix_tick   = w_pix_tick;
    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_visible    = (r_h_cnt < CNT_W'(H_VISIBLE)) && (r_v_cnt < CNT_W'(V_VISIBLE));
    assign o_hsync_n    = !((r_h_cnt >= CNT_W'(HS_FIRST)) && (r_h_cnt <= CNT_W'(HS_LAST)));
    assign o_vsync_n    = !((r_v_cnt >= CNT_W'(VS_FIRST)) && (r_v_cnt <= CNT_W'(VS_LAST)));
    assign o_vblank     = (r_v_cnt >= CNT_W'(V_VISIBLE));
    assign o_frame_wrap = w_pix_tick && w_h_last && (r_v_cnt == CNT_W'(V_VISIBLE - 1));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer read side and VGA DAC driver.
//   clk, resetn      : 50 MHz clock, synchronous active-low reset
//   rd_addr/rd_data  : synchronous framebuffer read port (data one clk later)
//   VGA_R/G/B        : 10-bit DAC values, each a replicated colour bit
//   VGA_HS/VS        : active-low syncs; VGA_BLANK low while blanking
//   VGA_SYNC         : constant 0; VGA_CLK: 25 MHz pixel clock
//   frame_start      : one-clk pulse entering vertical blanking
//   in_vblank        : high while the displayed line is in vertical blanking
// Pipeline: stage 1 issues the address and delays the timing bits, stage 2
// one pixel later registers the pins, so the pins trail the scan by one pixel.
module vga_scanout #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic        VGA_CLK,
    output logic        frame_start,
    output logic        in_vblank
);
    import vga_pkg::*;

    logic             w_phase;
    logic             w_pix_tick;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_visible;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_vblank;
    logic             w_frame_wrap;
    colour_t          w_colour;

    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_s1_visible, r_s1_hs, r_s1_vs, r_s1_vblank;
    logic [9:0]        r_vga_r, r_vga_g, r_vga_b;
    logic              r_vga_hs, r_vga_vs, r_vga_blank, r_vga_sync, r_vga_clk;
    logic              r_frame_start, r_in_vblank;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk          (clk),
        .resetn       (resetn),
        .o_phase      (w_phase),
        .o_pix_tick   (w_pix_tick),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_visible    (w_visible),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n),
        .o_vblank     (w_vblank),
        .o_frame_wrap (w_frame_wrap)
    );

    // Blanked pixels select BLACK, so rd_data (possibly X) never reaches the pins.
    assign w_colour = r_s1_visible ? colour_t'(rd_data) : BLACK;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_addr     <= '0;
            r_s1_visible  <= 1'b0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_vblank   <= 1'b0;
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_vga_blank   <= 1'b0;
            r_vga_sync    <= 1'b0;
            r_vga_clk     <= 1'b1;
            r_frame_start <= 1'b0;
            r_in_vblank   <= 1'b0;
        end else begin
            // Phase flips this edge, so ~next_phase equals the current phase.
            r_vga_clk     <= w_phase;
            r_vga_sync    <= 1'b0;
            r_frame_start <= w_frame_wrap;
            if (w_pix_tick) begin
                r_rd_addr    <= w_visible ? fb_addr(w_h_cnt[9:2], w_v_cnt[8:2]) : '0;
                r_s1_visible <= w_visible;
                r_s1_hs      <= w_hsync_n;
                r_s1_vs      <= w_vsync_n;
                r_s1_vblank  <= w_vblank;

                r_vga_r      <= {10{w_colour[2]}};
                r_vga_g      <= {10{w_colour[1]}};
                r_vga_b      <= {10{w_colour[0]}};
                r_vga_hs     <= r_s1_hs;
                r_vga_vs     <= r_s1_vs;
                r_vga_blank  <= r_s1_visible;
                r_in_vblank  <= r_s1_vblank;
            end
        end
    end

    assign rd_addr     = r_rd_addr;
    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_HS      = r_vga_hs;
    assign VGA_VS      = r_vga_vs;
    assign VGA_BLANK   = r_vga_blank;
    assign VGA_SYNC    = r_vga_sync;
    assign VGA_CLK     = r_vga_clk;
    assign frame_start = r_frame_start;
    assign in_vblank   = r_in_vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: two instances, one at full 640x480 timing (addresses,
// colour path, horizontal timing) and one with a shrunken frame so whole
// frames, vblank markers and resets fit in a short run. Both are compared
// every cycle against a pixel-index model of the scan.
module tb_vga_scanout;
    import vga_pkg::*;

    // Shrunken timing for instance b: 48 clocks-per-line pixels, 23 lines.
    localparam int BHV = 32, BHF = 4, BHS = 8, BHB = 4;
    localparam int BVV = 16, BVF = 2, BVS = 2, BVB = 3;
    localparam int LIM = 20000;

    typedef struct packed {
        logic [14:0] addr;
        logic [9:0]  r, g, b;
        logic        hs, vs, blank, sync, vclk, fs, vb;
    } obs_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        resetn_a, resetn_b;
    logic [14:0] addr_a, addr_b;
    logic [2:0]  data_a, data_b;
    logic [9:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a, vb_a;
    logic        hs_b, vs_b, blank_b, sync_b, vclk_b, fs_b, vb_b;

    int checks = 0;
    int errors = 0;
    int ka = -2;
    int kb = -2;

    colour_t fb [0:19199];

    vga_scanout u_dut_a (
        .clk(clk), .resetn(resetn_a), .rd_addr(addr_a), .rd_data(data_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
        .VGA_BLANK(blank_a), .VGA_SYNC(sync_a), .VGA_CLK(vclk_a),
        .frame_start(fs_a), .in_vblank(vb_a)
    );

    vga_scanout #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) u_dut_b (
        .clk(clk), .resetn(resetn_b), .rd_addr(addr_b), .rd_data(data_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
        .VGA_BLANK(blank_b), .VGA_SYNC(sync_b), .VGA_CLK(vclk_b),
        .frame_start(fs_b), .in_vblank(vb_b)
    );

    // Synchronous-read framebuffer model.
    always @(posedge clk) begin
        data_a <= fb[addr_a];
        data_b <= fb[addr_b];
    end

    // k = number of clk edges since the first edge with reset released (-1 in reset).
    always @(posedge clk) begin
        if (!resetn_a) ka = -1; else if (ka >= -1) ka = ka + 1;
        if (!resetn_b) kb = -1; else if (kb >= -1) kb = kb + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scan model: the edge k advances pixel index k/2 into the address stage
    // (on even k), and the pins show pixel k/2-1, i.e. one pixel later.
    function automatic obs_t model(input int k, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vbk);
        obs_t e;
        int ht, vt, p, q, ph, pv, qh, qv;
        colour_t c;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vbk;
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.vclk = 1'b1;
        if (k >= 0) begin
            e.vclk = (k % 2 == 1);
            p  = k / 2;
            ph = p % ht;
            pv = (p / ht) % vt;
            if (ph < hv && pv < vv) e.addr = 15'((pv / 4) * FB_WIDTH + ph / 4);
            e.fs = (k % 2 == 0) && (p % (ht * vt) == vv * ht - 1);
            q = k / 2 - 1;
            if (q >= 0) begin
                qh = q % ht;
                qv = (q / ht) % vt;
                e.blank = (qh < hv) && (qv < vv);
                e.hs = !(qh >= hv + hf && qh < hv + hf + hsw);
                e.vs = !(qv >= vv + vf && qv < vv + vf + vsw);
                e.vb = (qv >= vv);
                if (e.blank) begin
                    c = fb[(qv / 4) * FB_WIDTH + qh / 4];
                    e.r = {10{c[2]}}; e.g = {10{c[1]}}; e.b = {10{c[0]}};
                end
            end
        end
        return e;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (ka >= -1)
            check("scan_a", {addr_a, r_a, g_a, b_a, hs_a, vs_a, blank_a, sync_a, vclk_a, fs_a, vb_a},
                  model(ka, H_VISIBLE, H_FRONT, H_SYNC, H_BACK, V_VISIBLE, V_FRONT, V_SYNC, V_BACK));
        if (kb >= -1)
            check("scan_b", {addr_b, r_b, g_b, b_b, hs_b, vs_b, blank_b, sync_b, vclk_b, fs_b, vb_b},
                  model(kb, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB));
    end

    task automatic wait_ka(input int target);
        int n = 0;
        while (ka < target && n < 100000) begin @(negedge clk); n++; end
        if (ka != target) check("wait_ka_timeout", 64'(ka), 64'(target));
    endtask

    task automatic wait_kb(input int target);
        int n = 0;
        while (kb < target && n < 100000) begin @(negedge clk); n++; end
        if (kb != target) check("wait_kb_timeout", 64'(kb), 64'(target));
    endtask

    function automatic logic sel(input int s);
        case (s)
            0:       return hs_a;
            1:       return vs_b;
            2:       return fs_b;
            3:       return vb_b;
            default: return hs_b;
        endcase
    endfunction

    // Width of one active phase and full period of a signal, in clks.
    task automatic measure(input int s, input logic act, output int width, output int period);
        int n = 0;
        width = 0;
        period = 0;
        while (sel(s) == act && n < LIM) begin @(negedge clk); n++; end
        while (sel(s) != act && n < LIM) begin @(negedge clk); n++; end
        while (sel(s) == act && n < LIM) begin @(negedge clk); n++; width++; end
        period = width;
        while (sel(s) != act && n < LIM) begin @(negedge clk); n++; period++; end
        if (n >= LIM) begin width = -1; period = -1; end
    endtask

    initial begin
        int w, per, n, base;
        for (int i = 0; i < 19200; i++) fb[i] = colour_t'($urandom_range(0, 7));
        fb[0]   = WHITE;   // address 0 is what blanking reads: rd_data = 111
        fb[161] = YELLOW;  // 3'b110

        resetn_a = 1'b0;
        resetn_b = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_hs", 64'(hs_a), 64'(1));
        check("reset_vclk", 64'(vclk_a), 64'(1));
        resetn_a = 1'b1;
        resetn_b = 1'b1;

        // Address walk and pins on the full-size instance.
        wait_ka(2);    check("addr_h1", 64'(addr_a), 64'(0));
        wait_ka(6);    check("addr_h3", 64'(addr_a), 64'(0));
        wait_ka(8);    check("addr_h4", 64'(addr_a), 64'(1));
        wait_ka(1282); check("blank_h640", 64'(blank_a), 64'(0));
                       check("rgb_h640", 64'({r_a, g_a, b_a}), 64'(0));
        wait_ka(1313); check("hs_h655", 64'(hs_a), 64'(1));
        wait_ka(1314); check("hs_h656", 64'(hs_a), 64'(0));
        wait_ka(6400); check("addr_line4", 64'(addr_a), 64'(160));
        wait_ka(6408); check("addr_161", 64'(addr_a), 64'(161));
        wait_ka(6410); check("rgb_161_first", 64'({r_a, g_a, b_a}), {34'd0, 10'h3FF, 10'h3FF, 10'h000});
        wait_ka(6417); check("rgb_161_last", 64'({r_a, g_a, b_a}), {34'd0, 10'h3FF, 10'h3FF, 10'h000});

        measure(0, 1'b0, w, per);
        check("hs_a_low", 64'(w), 64'(192));
        check("hs_a_period", 64'(per), 64'(1600));

        // Frame-level timing on the shrunken instance (48 x 23 pixel frame).
        measure(1, 1'b0, w, per);
        check("vs_b_low", 64'(w), 64'(192));
        check("vs_b_period", 64'(per), 64'(2208));
        measure(2, 1'b1, w, per);
        check("fs_b_width", 64'(w), 64'(1));
        check("fs_b_period", 64'(per), 64'(2208));
        measure(3, 1'b1, w, per);
        check("vb_b_high", 64'(w), 64'(672));
        check("vb_b_period", 64'(per), 64'(2208));
        measure(4, 1'b0, w, per);
        check("hs_b_low", 64'(w), 64'(16));
        check("hs_b_period", 64'(per), 64'(96));

        // One-clk reset at line 10, pixel 20 of the next frame.
        base = (kb / 2208 + 1) * 2208 + 2 * (10 * 48 + 20);
        wait_kb(base);
        resetn_b = 1'b0;
        @(negedge clk);
        resetn_b = 1'b1;
        check("midrst_hs", 64'(hs_b), 64'(1));
        check("midrst_blank", 64'(blank_b), 64'(0));
        check("midrst_addr", 64'(addr_b), 64'(0));
        n = 0;
        while (hs_b !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
        // Pixel 36 reaches the pins 2*36 + 2 edges after release.
        check("midrst_hs_fall_k", 64'(kb), 64'(74));

        // Random reset pulses on instance b; the per-cycle compare covers recovery.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(100, 3000)) @(negedge clk);
            resetn_b = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            resetn_b = 1'b1;
        end
        repeat (500) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
